vga_sync_align: RTL and testbench

// Output stage downstream of the scandoubler, between its doubled-rate hs/vs/RGB and the VGA pins.
// Re-times vsync so each vsync edge lands on an hsync falling edge, delayed by VS_DELAY lines.

---
 rtl/vga_sync_align.sv | 132 +++++++++++++
 tb/tb_vga_sync_align.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_align.sv
// VGA output stage: re-times vsync onto hsync falling edges, builds the active-video
// window from line/pixel counters, blanks RGB outside it and drives DE.
module vga_sync_align #(
  parameter int VS_DELAY    = 1,
  parameter int H_ACT_START = 96,
  parameter int H_ACT_LEN   = 576,
  parameter int V_ACT_START = 16,
  parameter int V_ACT_LEN   = 448,
  parameter bit HS_INV      = 1'b0,
  parameter bit VS_INV      = 1'b0
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic       hs_out,
  output logic       vs_out,
  output logic [3:0] r_out,
  output logic [3:0] g_out,
  output logic [3:0] b_out,
  output logic       de,
  output logic [9:0] hlen
);

  generate
    if (VS_DELAY < 0 || VS_DELAY > 3) begin : g_bad_vs_delay
      $error("vga_sync_align: VS_DELAY must be in 0..3");
    end
  endgenerate

  // Clamped so the tap index stays legal while the elaboration error is reported.
  localparam int          TAP   = (VS_DELAY < 0) ? 0 : ((VS_DELAY > 3) ? 3 : VS_DELAY);
  localparam logic [10:0] H_BEG = 11'(H_ACT_START);
  localparam logic [10:0] H_END = 11'(H_ACT_START + H_ACT_LEN);
  localparam logic [10:0] V_BEG = 11'(V_ACT_START);
  localparam logic [10:0] V_END = 11'(V_ACT_START + V_ACT_LEN);

  logic        hs_d_q,     hs_d_d;
  logic [9:0]  hcnt_q,     hcnt_d;
  logic [9:0]  hlen_q,     hlen_d;
  logic [8:0]  vcnt_q,     vcnt_d;
  logic [3:0]  vs_sr_q,    vs_sr_d;
  logic [11:0] rgb_dly_q,  rgb_dly_d;
  logic [11:0] rgb_out_q,  rgb_out_d;
  logic        hs_out_q,   hs_out_d;
  logic        vs_out_q,   vs_out_d;
  logic        de_q,       de_d;

  logic ls;
  logic vs_al;
  logic h_act;
  logic v_act;

  assign ls    = hs_d_q & ~hs_in;
  assign vs_al = vs_sr_q[TAP];
  assign h_act = ({1'b0, hcnt_q} >= H_BEG) && ({1'b0, hcnt_q} < H_END);
  assign v_act = ({2'b0, vcnt_q} >= V_BEG) && ({2'b0, vcnt_q} < V_END);

  always_comb begin
    // NOTE: every next-state signal defaults to its hold value first, so no path infers a latch.
    hs_d_d    = hs_d_q;
    hcnt_d    = hcnt_q;
    hlen_d    = hlen_q;
    vcnt_d    = vcnt_q;
    vs_sr_d   = vs_sr_q;
    rgb_dly_d = rgb_dly_q;
    rgb_out_d = rgb_out_q;
    hs_out_d  = hs_out_q;
    vs_out_d  = vs_out_q;
    de_d      = de_q;

    if (ce_pix) begin
      hs_d_d    = hs_in;
      rgb_dly_d = {r_in, g_in, b_in};
      hs_out_d  = hs_d_q ^ HS_INV;
      vs_out_d  = vs_al ^ VS_INV;
      de_d      = h_act & v_act;
      rgb_out_d = (h_act & v_act) ? rgb_dly_q : 12'h000;

      if (ls) begin
        hcnt_d  = 10'd0;
        hlen_d  = hcnt_q + 10'd1;
        vs_sr_d = {vs_sr_q[2:0], vs_in};
        // A falling tap on this line start restarts the frame; it wins over the increment.
        if (vs_al && !vs_sr_d[TAP]) vcnt_d = 9'd0;
        else if (vcnt_q != 9'd511)  vcnt_d = vcnt_q + 9'd1;
      end else if (hcnt_q != 10'd1023) begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_d_q    <= 1'b1;
      hcnt_q    <= 10'd0;
      hlen_q    <= 10'd0;
      vcnt_q    <= 9'd0;
      vs_sr_q   <= 4'hF;
      rgb_dly_q <= 12'h000;
      rgb_out_q <= 12'h000;
      hs_out_q  <= 1'b1 ^ HS_INV;
      vs_out_q  <= 1'b1 ^ VS_INV;
      de_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      hs_d_q    <= hs_d_d;
      hcnt_q    <= hcnt_d;
      hlen_q    <= hlen_d;
      vcnt_q    <= vcnt_d;
      vs_sr_q   <= vs_sr_d;
      rgb_dly_q <= rgb_dly_d;
      rgb_out_q <= rgb_out_d;
      hs_out_q  <= hs_out_d;
      vs_out_q  <= vs_out_d;
      de_q      <= de_d;
    end
  end

  assign hs_out = hs_out_q;
  assign vs_out = vs_out_q;
  assign de     = de_q;
  assign r_out  = rgb_out_q[11:8];
  assign g_out  = rgb_out_q[7:4];
  assign b_out  = rgb_out_q[3:0];
  assign hlen   = hlen_q;

endmodule

// File: tb/tb_vga_sync_align.sv
// Bench for vga_sync_align: a cycle model pushes expected outputs into a queue per
// driven vector; each is popped and compared after the clock edge, plus directed checks.
module tb_vga_sync_align;

  localparam int VSD    = 1;
  localparam int H_S    = 96;
  localparam int H_L    = 576;
  localparam int V_S    = 16;
  localparam int V_L    = 6;
  localparam bit HS_INV = 1'b0;
  localparam bit VS_INV = 1'b0;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ce_pix;
  logic       hs_in;
  logic       vs_in;
  logic [3:0] r_in, g_in, b_in;
  logic       hs_out, vs_out, de;
  logic [3:0] r_out, g_out, b_out;
  logic [9:0] hlen;

  vga_sync_align #(
    .VS_DELAY(VSD), .H_ACT_START(H_S), .H_ACT_LEN(H_L),
    .V_ACT_START(V_S), .V_ACT_LEN(V_L), .HS_INV(HS_INV), .VS_INV(VS_INV)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_out(hs_out), .vs_out(vs_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .de(de), .hlen(hlen)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
    logic [9:0]  hlen;
  } out_t;

  out_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   en_cnt = 0;
  int   vs_fall_k = -1;
  int   hs_fall_k = -1;
  int   line_k = 0;
  int   cur_i = 0;
  int   line_de = 0;
  int   line_first = -1;
  int   line_last = -1;
  logic cur_vs = 1'b1;

  // Reference model state
  bit          m_hs_d;
  int          m_hcnt, m_hlen, m_vcnt;
  bit [3:0]    m_sr;
  logic [11:0] m_rgb_d;
  out_t        m_out;

  task automatic model_reset();
    m_hs_d  = 1'b1;
    m_hcnt  = 0;
    m_hlen  = 0;
    m_vcnt  = 0;
    m_sr    = 4'hF;
    m_rgb_d = 12'h000;
    m_out.hs   = 1'b1 ^ HS_INV;
    m_out.vs   = 1'b1 ^ VS_INV;
    m_out.de   = 1'b0;
    m_out.rgb  = 12'h000;
    m_out.hlen = 10'd0;
  endtask

  task automatic model_clock(input bit hs, input bit vs, input logic [11:0] rgb);
    bit ls, old_tap, ha, va;
    ls = m_hs_d && !hs;
    ha = (m_hcnt >= H_S) && (m_hcnt < H_S + H_L);
    va = (m_vcnt >= V_S) && (m_vcnt < V_S + V_L);
    m_out.hs  = m_hs_d ^ HS_INV;
    m_out.vs  = m_sr[VSD] ^ VS_INV;
    m_out.de  = ha && va;
    m_out.rgb = (ha && va) ? m_rgb_d : 12'h000;
    if (ls) begin
      m_hlen  = (m_hcnt + 1) % 1024;
      m_hcnt  = 0;
      old_tap = m_sr[VSD];
      m_sr    = {m_sr[2:0], vs};
      if (old_tap && !m_sr[VSD]) m_vcnt = 0;
      else                       m_vcnt = (m_vcnt < 511) ? m_vcnt + 1 : 511;
    end else begin
      m_hcnt = (m_hcnt < 1023) ? m_hcnt + 1 : 1023;
    end
    m_hs_d     = hs;
    m_rgb_d    = rgb;
    m_out.hlen = 10'(m_hlen);
  endtask

  task automatic step(input bit ce, input bit hs, input bit vs, input logic [11:0] rgb);
    out_t act, exp_v;
    logic prev_vs, prev_hs;
    @(negedge clk_sys);
    ce_pix = ce;
    hs_in  = hs;
    vs_in  = vs;
    {r_in, g_in, b_in} = rgb;
    prev_vs = vs_out;
    prev_hs = hs_out;
    if (ce) model_clock(hs, vs, rgb);
    exp_q.push_back(m_out);
    @(posedge clk_sys);
    #1;
    act   = {hs_out, vs_out, de, r_out, g_out, b_out, hlen};
    exp_v = exp_q.pop_front();
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL outputs @t=%0t: got hs=%b vs=%b de=%b rgb=%h hlen=%0d, expected hs=%b vs=%b de=%b rgb=%h hlen=%0d",
               $time, act.hs, act.vs, act.de, act.rgb, act.hlen,
               exp_v.hs, exp_v.vs, exp_v.de, exp_v.rgb, exp_v.hlen);
    end
    if (ce) begin
      if (prev_vs === 1'b1 && vs_out === 1'b0) vs_fall_k = en_cnt;
      if (prev_hs === 1'b1 && hs_out === 1'b0) hs_fall_k = en_cnt;
      if (de === 1'b1) begin
        line_de++;
        if (line_first < 0) line_first = cur_i;
        line_last = cur_i;
      end
      en_cnt++;
    end
  endtask

  // One line: hsync low for the first 96 enabled cycles, optional vs_in change at vs_at.
  task automatic run_line(input int len, input int vs_at, input bit vs_val,
                          input bit gaps, input logic [11:0] rgb);
    line_k     = en_cnt;
    line_de    = 0;
    line_first = -1;
    line_last  = -1;
    for (int i = 0; i < len; i++) begin
      if (i == vs_at) cur_vs = vs_val;
      cur_i = i;
      step(1'b1, (i >= 96), cur_vs, rgb);
      if (gaps) step(1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 12'($urandom));
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset  = 1'b1;
    ce_pix = 1'b0;
    cur_vs = 1'b1;
    model_reset();
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    out_t act, want;
    want = {1'b1 ^ HS_INV, 1'b1 ^ VS_INV, 1'b0, 12'h000, 10'd0};
    reset = 1'b1; ce_pix = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    {r_in, g_in, b_in} = 12'h000;
    model_reset();
    repeat (2) @(negedge clk_sys);
    #1;
    act = {hs_out, vs_out, de, r_out, g_out, b_out, hlen};
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL reset_initial: got %h expected %h", act, want);
    end
    @(negedge clk_sys);
    reset = 1'b0;
    run_line(800, -1, 1'b1, 1'b0, 12'h5AC);
    run_line(400, -1, 1'b1, 1'b0, 12'h5AC);
    // Assert reset between edges and look before the next clock edge arrives.
    @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    act = {hs_out, vs_out, de, r_out, g_out, b_out, hlen};
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL reset_midline_async: got %h expected %h", act, want);
    end
    model_reset();
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic test_line_measure();
    do_reset();
    for (int l = 0; l < 3; l++) run_line(800, -1, 1'b1, 1'b0, 12'h3C7);
    vectors++;
    if (hlen !== 10'd800) begin
      miscompares++;
      $display("FAIL line_measure_hlen: got %0d expected 800", hlen);
    end
    vectors++;
    if (hs_fall_k !== line_k + 1) begin
      miscompares++;
      $display("FAIL hs_out_delay: fall at %0d expected %0d", hs_fall_k, line_k + 1);
    end
  endtask

  // vs_in falls mid-line N; vs_out must fall one cycle after the ls of line N+2.
  task automatic test_vsync_align(input bit gaps);
    int k2;
    do_reset();
    vs_fall_k = -1;
    run_line(800, -1, 1'b1, gaps, 12'h111);
    run_line(800, 300, 1'b0, gaps, 12'h222);
    run_line(800, -1, 1'b0, gaps, 12'h333);
    vectors++;
    if (vs_fall_k !== -1) begin
      miscompares++;
      $display("FAIL vsync_early: fall at %0d expected none yet", vs_fall_k);
    end
    run_line(800, -1, 1'b0, gaps, 12'h444);
    k2 = line_k;
    run_line(800, -1, 1'b0, gaps, 12'h555);
    vectors++;
    if (vs_fall_k !== k2 + 1) begin
      miscompares++;
      $display("FAIL vsync_align gaps=%0d: fall at %0d expected %0d", gaps, vs_fall_k, k2 + 1);
    end
    vectors++;
    if (hlen !== 10'd800) begin
      miscompares++;
      $display("FAIL vsync_hlen gaps=%0d: got %0d expected 800", gaps, hlen);
    end
  endtask

  // Line j carries vcnt = j-2 once the vsync tap falls; active lines are j = 18..23.
  task automatic test_de_window();
    int exp_cnt;
    do_reset();
    for (int j = 0; j < 25; j++) begin
      run_line((j >= 18) ? 800 : 120, (j == 0) ? 50 : -1, 1'b0, 1'b0, 12'hFA5);
      exp_cnt = (j >= 18 && j <= 23) ? H_L : 0;
      vectors++;
      if (line_de !== exp_cnt) begin
        miscompares++;
        $display("FAIL de_count line %0d: got %0d expected %0d", j, line_de, exp_cnt);
      end
      if (exp_cnt != 0) begin
        vectors++;
        if (line_first !== H_S + 1 || line_last !== H_S + H_L) begin
          miscompares++;
          $display("FAIL de_edges line %0d: got %0d..%0d expected %0d..%0d",
                   j, line_first, line_last, H_S + 1, H_S + H_L);
        end
      end
    end
  endtask

  task automatic test_stuck_hsync();
    for (int i = 0; i < 2000; i++) step(1'b1, 1'b1, bit'($urandom_range(0, 1)), 12'($urandom));
    vectors++;
    if (dut.hcnt_q !== 10'd1023) begin
      miscompares++;
      $display("FAIL stuck_hcnt: got %0d expected 1023", dut.hcnt_q);
    end
    vectors++;
    if (hlen !== 10'd800 || de !== 1'b0 || vs_out !== (1'b0 ^ VS_INV)) begin
      miscompares++;
      $display("FAIL stuck_outputs: got hlen=%0d de=%b vs=%b expected hlen=800 de=0 vs=%b",
               hlen, de, vs_out, 1'b0 ^ VS_INV);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line_measure();
    test_vsync_align(1'b0);
    test_de_window();
    test_vsync_align(1'b1);
    test_stuck_hsync();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
